// File: rtl/idle_controller.sv
// Idle-state controller for the Simon game. Shows a rotating attract
// pattern while enabled, captures settings and a non-zero seed on a start
// press, and holds a launch request until the game FSM acknowledges it.
module idle_controller #(
  parameter int unsigned N_COLORS    = 4,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned LEVEL_W     = 2,
  parameter int unsigned SPEED_W     = 2,
  parameter int unsigned SEED_W      = 16,
  parameter int unsigned ATTRACT_DIV = 25_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_start,
  input  logic [MODE_W-1:0]   i_mode,
  input  logic [LEVEL_W-1:0]  i_level,
  input  logic [SPEED_W-1:0]  i_speed,
  input  logic                i_ack,
  output logic [MODE_W-1:0]   o_mode,
  output logic [LEVEL_W-1:0]  o_level,
  output logic [SPEED_W-1:0]  o_speed,
  output logic [SEED_W-1:0]   o_seed,
  output logic                o_ready,
  output logic [N_COLORS-1:0] o_leds,
  output logic                o_active,
  output logic                o_done
);

  localparam int unsigned         PRE_W     = (ATTRACT_DIV > 2) ? $clog2(ATTRACT_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(ATTRACT_DIV - 1);
  localparam logic [N_COLORS-1:0] LED_FIRST = N_COLORS'(1);
  localparam logic [SEED_W-1:0]   SEED_ONE  = SEED_W'(1);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ATTRACT  = 2'd1,
    S_LAUNCH   = 2'd2,
    S_HANDOFF  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [PRE_W-1:0]    pre, pre_nxt;
  logic [SEED_W-1:0]   free_cnt;
  logic                start_prev;
  logic                start_edge;

  logic [MODE_W-1:0]   mode_nxt;
  logic [LEVEL_W-1:0]  level_nxt;
  logic [SPEED_W-1:0]  speed_nxt;
  logic [SEED_W-1:0]   seed_nxt;
  logic                ready_nxt;
  logic [N_COLORS-1:0] leds_nxt;
  logic                active_nxt;
  logic                done_nxt;

  assign start_edge = i_start & ~start_prev;

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_DISABLED;
      pre        <= '0;
      free_cnt   <= '0;
      start_prev <= 1'b0;
      o_mode     <= '0;
      o_level    <= '0;
      o_speed    <= '0;
      o_seed     <= '0;
      o_ready    <= 1'b0;
      o_leds     <= '0;
      o_active   <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      free_cnt   <= free_cnt + SEED_W'(1);
      start_prev <= i_start;
      o_mode     <= mode_nxt;
      o_level    <= level_nxt;
      o_speed    <= speed_nxt;
      o_seed     <= seed_nxt;
      o_ready    <= ready_nxt;
      o_leds     <= leds_nxt;
      o_active   <= active_nxt;
      o_done     <= done_nxt;
    end
  end

  // Next-state and next-output logic; disable overrides start and ack
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    mode_nxt  = o_mode;
    level_nxt = o_level;
    speed_nxt = o_speed;
    seed_nxt  = o_seed;
    ready_nxt = o_ready;
    leds_nxt  = '0;
    done_nxt  = 1'b0;

    if (!i_enable) begin
      state_nxt = S_DISABLED;
      pre_nxt   = '0;
    end else begin
      case (state)
        S_DISABLED: begin
          state_nxt = S_ATTRACT;
          pre_nxt   = '0;
          leds_nxt  = LED_FIRST;
        end
        S_ATTRACT: begin
          if (start_edge) begin
            state_nxt = S_LAUNCH;
            pre_nxt   = '0;
            mode_nxt  = i_mode;
            level_nxt = i_level;
            speed_nxt = i_speed;
            seed_nxt  = (free_cnt == '0) ? SEED_ONE : free_cnt;
            ready_nxt = 1'b1;
            done_nxt  = 1'b1;
          end else if (pre == PRE_LAST) begin
            pre_nxt  = '0;
            leds_nxt = {o_leds[N_COLORS-2:0], o_leds[N_COLORS-1]};
          end else begin
            pre_nxt  = pre + PRE_W'(1);
            leds_nxt = o_leds;
          end
        end
        S_LAUNCH: begin
          if (i_ack) state_nxt = S_HANDOFF;
          else       done_nxt  = 1'b1;
        end
        S_HANDOFF: begin
          state_nxt = S_HANDOFF;
        end
        default: begin
          state_nxt = S_DISABLED;
        end
      endcase
    end

    active_nxt = (state_nxt != S_DISABLED);
  end

endmodule

// File: tb/tb_idle_controller.sv
// Directed bench for idle_controller: a vector table for attract, launch
// and handoff, then hand-written sequences for the multi-cycle corners.
module tb_idle_controller;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        ack;
  logic [1:0]  mode, level, speed;
  logic [1:0]  o_mode, o_level, o_speed;
  logic [15:0] o_seed;
  logic        o_ready;
  logic [3:0]  o_leds;
  logic        o_active;
  logic        o_done;

  int          checks;
  int          errors;
  logic [15:0] ref_cnt;
  logic [15:0] exp_seed;
  logic [15:0] last_seed;

  typedef struct {
    logic       en, start, ack;
    logic [1:0] mode, level, speed;
    logic       e_active, e_done, e_ready;
    logic [3:0] e_leds;
    logic [5:0] e_set;
    logic [15:0] e_seed;
  } vec_t;

  vec_t vq[$];

  idle_controller #(
    .N_COLORS(4), .MODE_W(2), .LEVEL_W(2), .SPEED_W(2),
    .SEED_W(16), .ATTRACT_DIV(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_start(start),
    .i_mode(mode), .i_level(level), .i_speed(speed), .i_ack(ack),
    .o_mode(o_mode), .o_level(o_level), .o_speed(o_speed), .o_seed(o_seed),
    .o_ready(o_ready), .o_leds(o_leds), .o_active(o_active), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running counter: cleared in reset, +1 every cycle
  always @(posedge clk) begin
    if (!rst_n) ref_cnt <= 16'd0;
    else        ref_cnt <= ref_cnt + 16'd1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic e_active, input logic e_done,
                           input logic e_ready, input logic [3:0] e_leds,
                           input logic [5:0] e_set, input logic [15:0] e_seed);
    chk({nm, " active"}, 16'(o_active), 16'(e_active));
    chk({nm, " done"},   16'(o_done),   16'(e_done));
    chk({nm, " ready"},  16'(o_ready),  16'(e_ready));
    chk({nm, " leds"},   16'(o_leds),   16'(e_leds));
    chk({nm, " set"},    16'({o_mode, o_level, o_speed}), 16'(e_set));
    chk({nm, " seed"},   o_seed,        e_seed);
  endtask

  task automatic add(input logic v_en, input logic v_start, input logic v_ack,
                     input logic [1:0] v_mode, input logic [1:0] v_level, input logic [1:0] v_speed,
                     input logic e_active, input logic e_done, input logic e_ready,
                     input logic [3:0] e_leds, input logic [5:0] e_set, input logic [15:0] e_seed);
    vec_t v;
    v.en = v_en; v.start = v_start; v.ack = v_ack;
    v.mode = v_mode; v.level = v_level; v.speed = v_speed;
    v.e_active = e_active; v.e_done = e_done; v.e_ready = e_ready;
    v.e_leds = e_leds; v.e_set = e_set; v.e_seed = e_seed;
    vq.push_back(v);
  endtask

  initial begin
    logic [3:0] one_hot;
    bit         wrapped;
    checks = 0;
    errors = 0;

    // Attract: each one-hot value held 4 cycles, wrapping back to bit 0
    for (int i = 0; i < 20; i++) begin
      one_hot = 4'b0001;
      one_hot = one_hot << ((i / 4) % 4);
      add(1, 0, 0, 2'd2, 2'd3, 2'd1, 1, 0, 0, one_hot, 6'd0, 16'd0);
    end
    // Press at edge 21: counter sampled = 20
    add(1, 1, 0, 2'd2, 2'd3, 2'd1, 1, 1, 1, 4'b0000, 6'b10_11_01, 16'd20);
    // Ten cycles without ack, switches moved and start re-pressed: nothing changes
    for (int i = 0; i < 10; i++)
      add(1, (i == 1), 0, 2'd1, 2'd0, 2'd3, 1, 1, 1, 4'b0000, 6'b10_11_01, 16'd20);
    // Ack drops done; block then sits in HANDOFF even on a new press
    add(1, 0, 1, 2'd1, 2'd0, 2'd3, 1, 0, 1, 4'b0000, 6'b10_11_01, 16'd20);
    add(1, 0, 0, 2'd1, 2'd0, 2'd3, 1, 0, 1, 4'b0000, 6'b10_11_01, 16'd20);
    add(1, 1, 0, 2'd1, 2'd0, 2'd3, 1, 0, 1, 4'b0000, 6'b10_11_01, 16'd20);
    add(1, 0, 0, 2'd1, 2'd0, 2'd3, 1, 0, 1, 4'b0000, 6'b10_11_01, 16'd20);

    // Reset with enable high and start low
    rst_n = 1'b0; en = 1'b1; start = 1'b0; ack = 1'b0;
    mode = 2'd0; level = 2'd0; speed = 2'd0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 4'b0000, 6'd0, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; start = vq[i].start; ack = vq[i].ack;
      mode = vq[i].mode; level = vq[i].level; speed = vq[i].speed;
      tick();
      check_all($sformatf("vec%0d", i), vq[i].e_active, vq[i].e_done, vq[i].e_ready,
                vq[i].e_leds, vq[i].e_set, vq[i].e_seed);
    end

    // Disable from HANDOFF: outputs idle, captured values kept
    en = 1'b0; start = 1'b0;
    tick();
    check_all("dis_handoff", 0, 0, 1, 4'b0000, 6'b10_11_01, 16'd20);

    // Start held across enable rising, ack in ATTRACT ignored
    start = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check_all("held_en", 1, 0, 1, 4'b0001, 6'b10_11_01, 16'd20);
    ack = 1'b1;
    tick();
    chk("held_ack done", 16'(o_done), 16'd0);
    ack = 1'b0;
    tick();
    chk("held2 done", 16'(o_done), 16'd0);
    start = 1'b0;
    tick();
    chk("release done", 16'(o_done), 16'd0);
    mode = 2'd1; level = 2'd2; speed = 2'd3; start = 1'b1;
    exp_seed = (ref_cnt == 16'd0) ? 16'd1 : ref_cnt;
    tick();
    check_all("repress", 1, 1, 1, 4'b0000, 6'b01_10_11, exp_seed);
    last_seed = exp_seed;

    // Drop enable in LAUNCH
    start = 1'b0; en = 1'b0;
    tick();
    check_all("dis_launch", 0, 0, 1, 4'b0000, 6'b01_10_11, last_seed);

    // Start edge in the same cycle enable falls: no capture
    en = 1'b1;
    tick();
    tick();
    check_all("attract2", 1, 0, 1, 4'b0001, 6'b01_10_11, last_seed);
    en = 1'b0; start = 1'b1; mode = 2'd3; level = 2'd1; speed = 2'd0;
    tick();
    check_all("edge_dis", 0, 0, 1, 4'b0000, 6'b01_10_11, last_seed);
    start = 1'b0;
    tick();

    // Reset during LAUNCH clears everything
    en = 1'b1;
    tick();
    mode = 2'd2; level = 2'd1; speed = 2'd2; start = 1'b1;
    tick();
    chk("launch3 done", 16'(o_done), 16'd1);
    start = 1'b0; rst_n = 1'b0;
    tick();
    check_all("rst_launch", 0, 0, 0, 4'b0000, 6'd0, 16'd0);
    rst_n = 1'b1;
    tick();
    check_all("rst_reen", 1, 0, 0, 4'b0001, 6'd0, 16'd0);
    tick();
    tick();
    chk("rst_nopress done", 16'(o_done), 16'd0);

    // Press exactly when the free-running counter has wrapped to 0
    wrapped = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (ref_cnt == 16'hFFFF) begin
        wrapped = 1'b1;
        break;
      end
      tick();
    end
    chk("wrap reached", 16'(wrapped), 16'd1);
    tick();
    mode = 2'd3; level = 2'd0; speed = 2'd1; start = 1'b1;
    tick();
    check_all("seed0", 1, 1, 1, 4'b0000, 6'b11_00_01, 16'd1);
    start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idle_controller.md
# idle_controller

Parametrised idle-state controller for the Simon game; successor to the single-cycle idle handler. While the top-level game FSM holds it enabled, it shows a rotating attract pattern on the colour LEDs. On a start press (rising edge) it captures the game settings and a random seed. It then raises `o_done` and holds it until the game FSM acknowledges, so the FSM cannot miss the hand-off pulse.

## Interface
Parameters
- `N_COLORS`, 4, number of colour channels / LEDs (≥2)
- `MODE_W`, 2, width of mode field
- `LEVEL_W`, 2, width of level field
- `SPEED_W`, 2, width of speed field
- `SEED_W`, 16, width of captured seed for the sequence LFSR
- `ATTRACT_DIV`, 25_000_000, clock cycles per attract-pattern step (≥2)

Ports
- `i_clk`  in  1  system clock; all logic on rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_enable`  in  1  game FSM is in IDLE
- `i_start`  in  1  start button, already debounced and synchronous to `i_clk`
- `i_mode`  in  MODE_W  mode switches
- `i_level`  in  LEVEL_W  level switches
- `i_speed`  in  SPEED_W  speed switches
- `i_ack`  in  1  game FSM has consumed the launch
- `o_mode` / `o_level` / `o_speed`  out  MODE_W / LEVEL_W / SPEED_W  captured settings
- `o_seed`  out  SEED_W  captured seed, never zero once `o_ready`=1
- `o_ready`  out  1  captured settings and seed valid
- `o_leds`  out  N_COLORS  attract pattern
- `o_active`  out  1  block enabled (any state except DISABLED)
- `o_done`  out  1  launch request, level, held until ack

## Operation
- States: DISABLED, ATTRACT, LAUNCH, HANDOFF.
- Reset (`i_rst_n`=0 at a clock edge):
  - state DISABLED.
  - All outputs 0, including settings, seed and `o_ready`.
  - Prescaler, free-running counter and start-history register cleared.
- Free-running counter: SEED_W bits, +1 every cycle in every state, wraps from all-ones to 0.
- Start edge: `start_prev` is a register updated every cycle; edge = `i_start` & ~`start_prev`.
  - If start is held when the block is enabled, no launch occurs until it is released and pressed again.
- DISABLED:
  - On `i_enable`=1, go to ATTRACT.
  - Prescaler cleared; `o_leds` loaded with one-hot bit 0.
- ATTRACT:
  - Prescaler counts 0..ATTRACT_DIV-1. At terminal count it returns to 0 and `o_leds` rotates left one position; bit N_COLORS-1 wraps to bit 0.
  - On a start edge:
    - capture `i_mode`/`i_level`/`i_speed` as sampled that cycle;
    - capture the free-running counter into `o_seed`, substituting 1 if it is 0;
    - set `o_ready`=1, `o_leds`=0, go to LAUNCH.
- LAUNCH:
  - `o_done`=1.
  - On `i_ack`=1, go to HANDOFF.
  - Further start edges are ignored; captured values do not change.
- HANDOFF: `o_done`=0, `o_leds`=0; remain here until `i_enable`=0.
- `i_enable`=0 in any state: next state DISABLED, `o_done`=0, `o_leds`=0.
  - Captured settings, seed and `o_ready` are retained, so the game uses them while idle is disabled.
  - They are overwritten only by the next capture and cleared only by reset.
- Priority: reset > `i_enable`=0 > start edge / `i_ack`.
  - Start edge coinciding with enable falling: no capture.
  - `i_ack` in ATTRACT or DISABLED: ignored.

## Timing
- All outputs registered; no combinational input→output paths.
- `i_enable` rises at edge t: `o_active`=1 and `o_leds`=one-hot bit 0 from t+1.
  - The first rotation occurs ATTRACT_DIV cycles after ATTRACT is entered.
- Start edge sampled at edge t in ATTRACT: at t+1, `o_done`=1, `o_ready`=1, settings/seed valid and `o_leds`=0.
  - Seed equals the counter value sampled at t (or 1 if that value is 0).
- `i_ack` sampled at edge t in LAUNCH: `o_done`=0 at t+1.
- `i_enable` falls at edge t: `o_active`=0, `o_done`=0 and `o_leds`=0 at t+1.
- Reset mid-LAUNCH: all outputs 0 at the next edge; a new press is required after re-enable.

## Test plan
- Reset with `i_enable`=1, `i_start`=0:
  - all outputs 0 during reset;
  - after release, `o_active`=1 and `o_leds`=4'b0001 one cycle later.
- ATTRACT_DIV=4, N_COLORS=4, run 20 cycles: `o_leds` sequence 0001→0010→0100→1000→0001, each value held exactly 4 cycles.
- Switches mode=2, level=3, speed=1; pulse start at a known cycle:
  - next cycle `o_done`=1, `o_ready`=1, settings = 2/3/1, `o_seed` = reference counter value;
  - `o_done` stays 1 for 10 cycles without ack;
  - `i_ack` pulse → `o_done`=0 on the next cycle, and the block stays in HANDOFF.
- Force the counter to 0 at the start edge (press 65 536 cycles after reset, SEED_W=16) → `o_seed`=1.
- `i_start` held high before and through `i_enable` rising: no `o_done`; after release and re-press, `o_done`=1 one cycle after the press.
- Edge cases:
  - start edge in the same cycle `i_enable` falls → no capture, prior settings kept;
  - drop `i_enable` in LAUNCH → `o_done`=0 next cycle, settings retained;
  - reset in LAUNCH → everything 0.
